// File: rtl/final_nios_system_led_out.sv
// final_nios_system_led_out: Avalon-MM output PIO with atomic set/clear and a self-timed one-shot pulse.
// out_port = data_reg ^ pulse_mask, both registered, so there is no bus-to-pin combinational path.
module final_nios_system_led_out #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int PULSE_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES);
  logic [WIDTH-1:0] data_reg, pulse_mask, wd;
  logic [CW-1:0] cnt;
  logic wr, pulse_wr, unused_upper;
  logic [31:0] rd_next;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_upper = ^writedata;
  assign pulse_wr = wr && address == 3'd2;
  assign out_port = data_reg ^ pulse_mask;
  always_comb
    rd_next = address == 3'd0 ? 32'(data_reg)
            : address == 3'd2 ? 32'(pulse_mask)
            : address == 3'd3 ? {31'd0, cnt != '0}
            : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) data_reg <= RESET_VALUE;
    else if (wr && address == 3'd0) data_reg <= wd;
    else if (wr && address == 3'd4) data_reg <= data_reg | wd;
    else if (wr && address == 3'd5) data_reg <= data_reg & ~wd;
  // a PULSE write wins over expiry, so re-arming in the last cycle leaves no gap
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pulse_mask <= '0;
      cnt <= '0;
    end else if (pulse_wr) begin
      pulse_mask <= |wd ? pulse_mask | wd : '0;
      cnt <= |wd ? LOAD : '0;
    end else if (cnt == CW'(1)) begin
      pulse_mask <= '0;
      cnt <= '0;
    end else if (cnt != '0) cnt <= cnt - CW'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= rd_next;
endmodule

// File: tb/tb_final_nios_system_led_out.sv
// tb_final_nios_system_led_out: scoreboard bench; per-cycle expectations queued at drive time, compared after the edge.
module tb_final_nios_system_led_out;
  logic clk = 0, reset_n = 1, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [7:0] out_port;
  typedef struct packed {logic [7:0] o; logic [31:0] r;} exp_t;
  exp_t sb[$];
  logic [7:0] m_data = 8'hA5, m_mask = 0;
  int m_cnt = 0, checks = 0, errors = 0;

  final_nios_system_led_out #(.WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return {24'd0, m_data};
    if (a == 3'd2) return {24'd0, m_mask};
    if (a == 3'd3) return {31'd0, m_cnt != 0};
    return 32'd0;
  endfunction

  task automatic cyc(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    exp_t e;
    logic w;
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    w = cs && !wn;
    e.r = m_read(a);
    if (w && a == 3'd0) m_data = wd[7:0];
    if (w && a == 3'd4) m_data = m_data | wd[7:0];
    if (w && a == 3'd5) m_data = m_data & ~wd[7:0];
    if (w && a == 3'd2) begin
      if (wd[7:0] != 0) begin m_mask = m_mask | wd[7:0]; m_cnt = 4; end
      else begin m_mask = 0; m_cnt = 0; end
    end else if (m_cnt == 1) begin m_mask = 0; m_cnt = 0; end
    else if (m_cnt > 1) m_cnt--;
    e.o = m_data ^ m_mask;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check($sformatf("out a=%0d", a), {24'd0, out_port}, {24'd0, e.o});
    check($sformatf("rd a=%0d", a), readdata, e.r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'd3, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    #2 reset_n = 0;
    #1;
    check("reset out", {24'd0, out_port}, 32'hA5);
    check("reset rd", readdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    cyc(3'd0, 1'b1, 1'b1, 32'd0);
    check("rd data A5", readdata, 32'hA5);
    cyc(3'd1, 1'b1, 1'b1, 32'd0);
    cyc(3'd6, 1'b1, 1'b1, 32'd0);
    cyc(3'd7, 1'b1, 1'b1, 32'd0);
    cyc(3'd1, 1'b1, 1'b0, 32'hFF);
    cyc(3'd0, 1'b1, 1'b0, 32'h3C);
    cyc(3'd4, 1'b1, 1'b0, 32'h81);
    check("outset BD", {24'd0, out_port}, 32'hBD);
    cyc(3'd5, 1'b1, 1'b0, 32'h0C);
    check("outclr B1", {24'd0, out_port}, 32'hB1);
    cyc(3'd4, 1'b1, 1'b1, 32'd0);
    cyc(3'd5, 1'b1, 1'b1, 32'd0);
    cyc(3'd0, 1'b0, 1'b0, 32'hFF);
    check("no cs B1", {24'd0, out_port}, 32'hB1);
    cyc(3'd0, 1'b1, 1'b0, 32'h0F);
    cyc(3'd2, 1'b1, 1'b0, 32'h11);
    check("pulse 1E", {24'd0, out_port}, 32'h1E);
    idle(3);
    check("pulse T+3", {24'd0, out_port}, 32'h1E);
    idle(1);
    check("pulse end 0F", {24'd0, out_port}, 32'h0F);
    cyc(3'd3, 1'b1, 1'b1, 32'd0);
    cyc(3'd2, 1'b1, 1'b0, 32'h11);
    idle(1);
    cyc(3'd2, 1'b1, 1'b0, 32'h02);
    check("rearm 1C", {24'd0, out_port}, 32'h1C);
    idle(5);
    cyc(3'd2, 1'b1, 1'b0, 32'h01);
    idle(3);
    cyc(3'd2, 1'b1, 1'b0, 32'h02);
    check("expiry rearm 0C", {24'd0, out_port}, 32'h0C);
    cyc(3'd3, 1'b1, 1'b1, 32'd0);
    cyc(3'd2, 1'b1, 1'b0, 32'h00);
    check("cancel 0F", {24'd0, out_port}, 32'h0F);
    cyc(3'd3, 1'b1, 1'b1, 32'd0);
    check("cancel status", readdata, 32'd0);
    cyc(3'd2, 1'b1, 1'b0, 32'h11);
    cyc(3'd0, 1'b1, 1'b0, 32'hF0);
    check("data mid pulse E1", {24'd0, out_port}, 32'hE1);
    idle(1);
    reset_n = 0;
    m_data = 8'hA5; m_mask = 0; m_cnt = 0;
    #1;
    check("async reset out", {24'd0, out_port}, 32'hA5);
    @(negedge clk) reset_n = 1;
    cyc(3'd3, 1'b1, 1'b1, 32'd0);
    cyc(3'd2, 1'b1, 1'b1, 32'd0);
    check("post reset status", m_read(3'd3), 32'd0);
    for (int i = 0; i < 300; i++)
      cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/final_nios_system_led_out.md
# final_nios_system_led_out

Avalon-MM slave output port for the Nios II system: software writes a register and the block drives `out_port` to board LEDs and other outputs. It is the write-direction counterpart of the system's read-only input PIOs. It adds atomic bit set/clear and a self-timed one-shot pulse so that software can blink or strobe outputs without polling a timer. It sits on the Nios data master interconnect next to the input PIOs and uses the same registered-readdata convention.

## Interface
- `WIDTH`, default 8: output port width, legal range 1..32.
- `RESET_VALUE`, default 0: value of the data register after reset (WIDTH bits).
- `PULSE_CYCLES`, default 50000000: length of a one-shot pulse in clk cycles, minimum 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word offset.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits [WIDTH-1:0] are used, upper bits are ignored.
- `readdata`  out  32  registered read data; bits above WIDTH read 0.
- `out_port`  out  WIDTH  driven output, equal to `data_reg ^ pulse_mask`.

## Operation
- A write occurs when `chipselect`=1 and `write_n`=0 at a rising edge. A write with `chipselect`=0 has no effect.
- Register map:
  - 0 DATA, R/W: write sets `data_reg <= wd`; read returns `data_reg`.
  - 1: reserved; writes are ignored and reads return 0.
  - 2 PULSE, R/W:
    - Write of a nonzero value: `pulse_mask <= pulse_mask | wd` and `cnt <= PULSE_CYCLES`.
    - Write of 0: cancels the pulse (`pulse_mask <= 0`, `cnt <= 0`).
    - Read returns `pulse_mask`.
  - 3 STATUS, RO: bit0 = pulse active (`cnt != 0`); all other bits read 0.
  - 4 OUTSET, WO: `data_reg <= data_reg | wd`; reads return 0.
  - 5 OUTCLEAR, WO: `data_reg <= data_reg & ~wd`; reads return 0.
  - 6, 7: reserved; reads return 0.
- Pulse counter:
  - Width is ceil(log2(PULSE_CYCLES+1)).
  - When there is no PULSE write and `cnt` > 1: `cnt` decrements by 1.
  - When there is no PULSE write and `cnt` = 1: `cnt <= 0` and `pulse_mask <= 0`.
  - When `cnt` = 0: the counter is idle.
- Simultaneous events:
  - A PULSE write in the expiry cycle (`cnt` = 1) takes priority. The pulse restarts with `old_mask | wd`.
  - A DATA, OUTSET or OUTCLEAR write during an active pulse updates `data_reg` only. The pulse keeps running and remains XORed onto `out_port`.
- Pulse bits invert the corresponding `data_reg` bits, so a pulse on an output that is already lit turns it off for the pulse duration.
- Reset: `data_reg` = RESET_VALUE, `pulse_mask` = 0, `cnt` = 0, `readdata` = 0, `out_port` = RESET_VALUE.
  - Reset takes effect immediately when asserted, including mid-pulse or mid-write.

## Timing
- Every state update happens at the rising edge that samples the write. `out_port` shows the new value from that edge onward, i.e. one cycle after the write is presented.
- `readdata` is registered and reloaded on every clock from the current `address`, regardless of `chipselect`. Read latency is 1 cycle.
- A read in the same cycle as a write to the same register returns the pre-write value. The next cycle returns the new value.
- Pulse duration: a PULSE write sampled at edge T holds the mask over the next PULSE_CYCLES edges; `out_port` shows the pulse from edge T through edge T+PULSE_CYCLES-1.
  - Example: with PULSE_CYCLES=4, the mask is visible in cycles T+1..T+4 and cleared at edge T+4. `out_port` returns to `data_reg` from cycle T+5.
- `out_port` is the XOR of two flops. It has no combinational path from the bus inputs.

## Test plan
Use WIDTH=8 and PULSE_CYCLES=4.
- Reset with RESET_VALUE=0xA5 -> `out_port`=0xA5 and `readdata`=0. Then read addr 0 -> `readdata`=0xA5 one cycle later; read addrs 1, 6, 7 -> 0.
- Write DATA 0x3C, then OUTSET 0x81 -> `out_port`=0xBD; then OUTCLEAR 0x0C -> 0xB1. Read addr 4 or 5 -> 0. A write with `chipselect`=0 and `write_n`=0 leaves 0xB1 unchanged.
- DATA=0x0F, write PULSE 0x11 at edge T -> `out_port`=0x1E in cycles T+1..T+4 and 0x0F from T+5. STATUS bit0 reads 1 during the pulse and 0 after it.
- Re-arm at edge T+2 with PULSE 0x02 -> mask becomes 0x13 and `out_port`=0x1C until the pulse expires 4 cycles after T+2. Re-arm exactly in the expiry cycle -> the pulse restarts with no gap on `out_port`.
- Write PULSE 0 mid-pulse -> `out_port` returns to `data_reg` on the next cycle and STATUS=0. Write DATA 0xF0 mid-pulse -> `out_port` = 0xF0 ^ mask.
- Assert `reset_n` mid-pulse -> `out_port` equals RESET_VALUE immediately, with STATUS=0 and PULSE readback=0 after release.
